sharp_factor_pwl: RTL
=====================

Name: sharp_factor_pwl

Overview:
Parametrised successor of the SPR sharpness-factor generator. Maps the current sharpness metric onto a programmable piecewise-linear weight curve with SEGS segments. Scales the result by a global sharpness gain. Breakpoints and per-segment left/right slopes are run-time programmable through a double-buffered config port that commits only during vertical blanking. Sits in the SPR sharpening path between the sharpness-metric extractor and the per-subpixel amount multiplier.

Parameters:
DW, 12, data width of the metric, breakpoints and output amount
SEGS, 4, segment count; power of 2, range 2..16
WW, 5, slope weight width, unsigned Q1.4 (16 = 1.0)
GW, 12, gain width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_hs  in  1  line active; low = pipeline clear
i_vs  in  1  frame active; low = pipeline clear, commit window
shp_en  in  1  pipeline advance / input valid
shp_curr  in  DW  current sharpness metric
shp_sel  in  1  force weighted factor to zero (travels with the sample)
spr_sharp_prt  in  1  1 = output gain*factor; 0 = output gain directly
sharp_gain  in  GW  global sharpness amount
cfg_we  in  1  shadow table write strobe
cfg_addr  in  $clog2(SEGS+1)  table index
cfg_bp  in  DW  breakpoint bp[addr]
cfg_wl  in  WW  left slope wl[addr]; ignored when addr = SEGS
cfg_wr  in  WW  right slope wr[addr]; ignored when addr = SEGS
cfg_commit  in  1  request shadow-to-active copy
cfg_pending  out  1  commit requested but not yet applied
amout  out  DW  sharpness amount, Q2.10 at default widths
amout_vld  out  1  amout valid

Behaviour:
- Reset state: all pipeline registers, amout and amout_vld = 0; cfg_pending = 0.
- Reset table contents (shadow and active): bp[k] = k*2^DW/SEGS, with bp[SEGS] = 2^DW-1.
- Reset slopes at default SEGS=4: wl = {16,12,8,4}, wr = {12,8,4,2} for segments 0..3. Other SEGS: wl = 16, wr = 8 for all segments.
- Pipeline clear: when !i_hs || !i_vs, all pipeline registers and outputs are cleared to 0 synchronously. Tables are not affected. Clear has priority over shp_en. rst has priority over everything.
- When shp_en = 0 and there is no clear, every pipeline register holds.
- Pipeline, 4 shp_en-qualified stages:
  S1: segment k = highest index in 0..SEGS-1 with x >= bp[k], else 0. dl = max(bp[k+1]-x, 0); dr = max(x-bp[k], 0). Register dl, dr, k, shp_sel.
  S2: tl = (dl*wl[k])>>4; tr = (dr*wr[k])>>4. Both are 0 if the registered shp_sel = 1.
  S3: f = sat_DW(tl+tr) with the LSB cleared.
  S4: if spr_sharp_prt, amout = sat_DW((sharp_gain*f)>>4); else amout = sharp_gain[DW-1:0]. spr_sharp_prt and sharp_gain are sampled at S4.
- Latency: amout is valid 4 shp_en cycles after sample entry. amout_vld mirrors a 4-deep valid shift register, advanced by shp_en and cleared by pipeline clear.
- Table selection: S1 and S2 read the active tables only. A sample in S2 uses the same table generation as in S1, so a commit never splits a sample across table generations.
- Config writes: cfg_we writes the shadow table at any time. Out-of-range cfg_addr is ignored.
- Commit: cfg_commit sets cfg_pending. On the first cycle with cfg_pending = 1 and i_vs = 0, shadow is copied to active and cfg_pending clears.
- Commit collisions: cfg_commit in the same cycle as the copy keeps cfg_pending = 1. cfg_we in the same cycle as the copy writes shadow only; the copy uses pre-write shadow contents.
- Non-monotonic breakpoints are legal. Segment selection uses the highest-index rule, and dl/dr clamp at 0.

Decomposition:
- Shared package spr_pkg holds: default DW/SEGS/WW/GW, the reset breakpoint/slope vectors, the Q1.4 unity constant (16), and the sat_DW function.
- One sub-module, pwl_seg_lookup: combinational comparator tree plus dl/dr/k computation for S1, parametrised by DW and SEGS.

Test Plan:
- Defaults, prt=1, gain=64, x=1500, sel=0 -> k=1, dl=548, dr=476, tl=411, tr=238, f=648, amout=2592, 4 cycles later with amout_vld=1.
- Defaults, prt=1, gain=16, x=4095 -> k=3, dl=0, tr=127, f=126, amout=126. Same x with prt=0 -> amout=16.
- Saturation: gain=4095, x=0, prt=1 -> f=1024, amout=4095. shp_sel=1 on the same sample -> amout=0.
- Stall/clear: toggle shp_en mid-stream -> outputs hold during stall. Drop i_hs for 1 cycle with 3 samples in flight -> amout=0, amout_vld=0 next cycle, no stale sample emerges.
- Commit: write bp[1]=512 and wl[1]=16 with i_vs=1, pulse commit -> cfg_pending=1 and results unchanged. Lower i_vs -> copy occurs, pending=0. After i_vs rises, x=1500 resolves to k=1 against bp[1]=512.
- Reset mid-operation: assert rst with valid data in flight -> all outputs 0 and tables back to defaults next cycle.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared constants and helpers for the SPR sharpness path: default widths,
// reset curve shapes, the Q1.4 unity weight and unsigned saturation.
package spr_pkg;

   localparam int unsigned DefDw   = 12;
   localparam int unsigned DefSegs = 4;
   localparam int unsigned DefWw   = 5;
   localparam int unsigned DefGw   = 12;

   // Q1.4 slope weight equal to 1.0
   localparam int unsigned QOne = 16;

   // Reset slopes for the four-segment curve, segment 0 in the low byte
   localparam logic [31:0] RstWl4 = {8'd4, 8'd8, 8'd12, 8'd16};
   localparam logic [31:0] RstWr4 = {8'd2, 8'd4, 8'd8, 8'd12};

   // Flat reset slopes for any other segment count
   localparam int unsigned RstWlFlat = QOne;
   localparam int unsigned RstWrFlat = 8;

   // Evenly spaced breakpoints; the closing breakpoint sits at full scale
   function automatic logic [63:0] rst_bp(input int unsigned dw, input int unsigned segs,
                                          input int unsigned k);
      logic [63:0] full;
      full = 64'd1 << dw;
      if (k >= segs) return full - 64'd1;
      return (64'(k) * full) / 64'(segs);
   endfunction

   function automatic int unsigned rst_wl(input int unsigned segs, input int unsigned k);
      return (segs == 4) ? ((RstWl4 >> (8 * k)) & 32'hff) : RstWlFlat;
   endfunction

   function automatic int unsigned rst_wr(input int unsigned segs, input int unsigned k);
      return (segs == 4) ? ((RstWr4 >> (8 * k)) & 32'hff) : RstWrFlat;
   endfunction

   // Clamp an unsigned value to the largest dw-bit code
   function automatic logic [63:0] sat_dw(input logic [63:0] v, input int unsigned dw);
      logic [63:0] max_v;
      max_v = (64'd1 << dw) - 64'd1;
      return (v > max_v) ? max_v : v;
   endfunction

endpackage

// File: rtl/pwl_seg_lookup.sv
// Segment lookup for the piecewise-linear sharpness curve: picks the highest
// segment whose left breakpoint is at or below x and returns the clamped
// distances to both ends of that segment.
module pwl_seg_lookup #(
   parameter int unsigned DW   = 12,
   parameter int unsigned SEGS = 4
) (
   input  logic [DW-1:0]                x,
   input  logic [SEGS:0][DW-1:0]        bp,
   output logic [$clog2(SEGS)-1:0]      k,
   output logic [DW-1:0]                dl,
   output logic [DW-1:0]                dr
);

   localparam int unsigned AW = $clog2(SEGS + 1);
   localparam int unsigned KW = $clog2(SEGS);

   logic [DW-1:0] lo;
   logic [DW-1:0] hi;

   // Priority comparator chain; later (higher) segments win, so unordered
   // breakpoints still resolve deterministically
   always_comb begin
      k  = '0;
      lo = bp[0];
      hi = bp[1];
      for (int unsigned i = 1; i < SEGS; i++) begin
         if (x >= bp[AW'(i)]) begin
            k  = KW'(i);
            lo = bp[AW'(i)];
            hi = bp[AW'(i + 1)];
         end
      end
      dl = (hi > x) ? hi - x : '0;
      dr = (x > lo) ? x - lo : '0;
   end

endmodule

// File: rtl/sharp_factor_pwl.sv
// Sharpness factor generator: four-stage pipeline mapping the sharpness metric
// through a programmable piecewise-linear curve and a global gain, with a
// double-buffered curve table that only switches during vertical blanking.
module sharp_factor_pwl
   import spr_pkg::*;
#(
   parameter int unsigned DW   = DefDw,
   parameter int unsigned SEGS = DefSegs,
   parameter int unsigned WW   = DefWw,
   parameter int unsigned GW   = DefGw
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_hs,
   input  logic                        i_vs,
   input  logic                        shp_en,
   input  logic [DW-1:0]               shp_curr,
   input  logic                        shp_sel,
   input  logic                        spr_sharp_prt,
   input  logic [GW-1:0]               sharp_gain,
   input  logic                        cfg_we,
   input  logic [$clog2(SEGS+1)-1:0]   cfg_addr,
   input  logic [DW-1:0]               cfg_bp,
   input  logic [WW-1:0]               cfg_wl,
   input  logic [WW-1:0]               cfg_wr,
   input  logic                        cfg_commit,
   output logic                        cfg_pending,
   output logic [DW-1:0]               amout,
   output logic                        amout_vld
);

   localparam int unsigned AW  = $clog2(SEGS + 1);
   localparam int unsigned KW  = $clog2(SEGS);
   localparam int unsigned PLW = DW + WW;   // distance * slope product
   localparam int unsigned TW  = PLW - 4;   // product after dropping Q1.4 fraction
   localparam int unsigned SW  = TW + 1;    // left + right term sum
   localparam int unsigned PW  = GW + DW;   // gain * factor product

   // Curve tables: shadow is written by software, active feeds the pipeline
   logic [SEGS:0][DW-1:0]   bp_q, bp_sh_q;
   logic [SEGS-1:0][WW-1:0] wl_q, wr_q, wl_sh_q, wr_sh_q;
   logic                    pending_q, pending_d, copy;

   logic clr;
   assign clr  = !i_hs || !i_vs;
   assign copy = pending_q && !i_vs;

   // Commit request: a new request in the copy cycle stays pending
   always_comb begin
      pending_d = pending_q;
      if (cfg_commit)  pending_d = 1'b1;
      else if (copy)   pending_d = 1'b0;
   end

   // Table state; the copy reads pre-write shadow since both are registered here
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k <= SEGS; k++) begin
            bp_q[AW'(k)]    <= DW'(rst_bp(DW, SEGS, k));
            bp_sh_q[AW'(k)] <= DW'(rst_bp(DW, SEGS, k));
         end
         for (int unsigned k = 0; k < SEGS; k++) begin
            wl_q[KW'(k)]    <= WW'(rst_wl(SEGS, k));
            wr_q[KW'(k)]    <= WW'(rst_wr(SEGS, k));
            wl_sh_q[KW'(k)] <= WW'(rst_wl(SEGS, k));
            wr_sh_q[KW'(k)] <= WW'(rst_wr(SEGS, k));
         end
         pending_q <= 1'b0;
      end else begin
         if (copy) begin
            bp_q <= bp_sh_q;
            wl_q <= wl_sh_q;
            wr_q <= wr_sh_q;
         end
         if (cfg_we && (32'(cfg_addr) <= SEGS)) begin
            bp_sh_q[cfg_addr] <= cfg_bp;
            if (32'(cfg_addr) < SEGS) begin
               wl_sh_q[KW'(cfg_addr)] <= cfg_wl;
               wr_sh_q[KW'(cfg_addr)] <= cfg_wr;
            end
         end
         pending_q <= pending_d;
      end
   end

   // Pipeline registers
   logic [DW-1:0] s1_dl_q, s1_dr_q;
   logic [WW-1:0] s1_wl_q, s1_wr_q;
   logic          s1_sel_q;
   logic [TW-1:0] s2_tl_q, s2_tr_q;
   logic [DW-1:0] s3_f_q;
   logic [DW-1:0] amout_q;
   logic [3:0]    vld_q;

   // Stage next-state values
   logic [KW-1:0]  seg_k;
   logic [DW-1:0]  s1_dl_d, s1_dr_d;
   logic [PLW-1:0] prod_l, prod_r;
   logic [TW-1:0]  s2_tl_d, s2_tr_d;
   logic [SW-1:0]  sum;
   logic [DW-1:0]  f_sat, s3_f_d;
   logic [PW-1:0]  gprod;
   logic [DW-1:0]  amout_d;

   pwl_seg_lookup #(
      .DW   (DW),
      .SEGS (SEGS)
   ) u_lookup (
      .x  (shp_curr),
      .bp (bp_q),
      .k  (seg_k),
      .dl (s1_dl_d),
      .dr (s1_dr_d)
   );

   // S2..S4 datapath: weighting, factor saturation, gain scaling
   always_comb begin
      prod_l  = PLW'(s1_dl_q) * PLW'(s1_wl_q);
      prod_r  = PLW'(s1_dr_q) * PLW'(s1_wr_q);
      s2_tl_d = s1_sel_q ? '0 : prod_l[PLW-1:4];
      s2_tr_d = s1_sel_q ? '0 : prod_r[PLW-1:4];
      sum     = SW'(s2_tl_q) + SW'(s2_tr_q);
      f_sat   = DW'(sat_dw(64'(sum), DW));
      s3_f_d  = {f_sat[DW-1:1], 1'b0};
      gprod   = PW'(sharp_gain) * PW'(s3_f_q);
      amout_d = spr_sharp_prt ? DW'(sat_dw(64'(gprod >> 4), DW)) : DW'(sharp_gain);
   end

   // Pipeline advance; slopes are captured with the sample so S2 always uses
   // the same table generation that S1 resolved the segment against
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         s1_dl_q  <= '0;
         s1_dr_q  <= '0;
         s1_wl_q  <= '0;
         s1_wr_q  <= '0;
         s1_sel_q <= 1'b0;
         s2_tl_q  <= '0;
         s2_tr_q  <= '0;
         s3_f_q   <= '0;
         amout_q  <= '0;
         vld_q    <= '0;
      end else if (shp_en) begin
         s1_dl_q  <= s1_dl_d;
         s1_dr_q  <= s1_dr_d;
         s1_wl_q  <= wl_q[seg_k];
         s1_wr_q  <= wr_q[seg_k];
         s1_sel_q <= shp_sel;
         s2_tl_q  <= s2_tl_d;
         s2_tr_q  <= s2_tr_d;
         s3_f_q   <= s3_f_d;
         amout_q  <= amout_d;
         vld_q    <= {vld_q[2:0], 1'b1};
      end
   end

   assign amout       = amout_q;
   assign amout_vld   = vld_q[3];
   assign cfg_pending = pending_q;

endmodule
